// File: rtl/reaction_game_core_if.sv
// Player-facing bundle of the reaction game core: raw button in, digits/status out.
interface reaction_game_core_if;
  logic       btn;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [1:0] state;
  logic       go;
  logic       false_start;
  logic       timeout;

  // Driver side (board / testbench): supplies the button, observes the game.
  modport master (
    output btn,
    input  tens, ones, state, go, false_start, timeout
  );

  // Game core side.
  modport slave (
    input  btn,
    output tens, ones, state, go, false_start, timeout
  );
endinterface

// File: rtl/reaction_game_core.sv
// Reaction-timer game engine: button conditioning, game FSM, BCD reaction count.
module reaction_game_core #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned DEBOUNCE  = 50000,
  parameter int unsigned MIN_DELAY = 100,
  parameter int unsigned LOCKOUT   = 50,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  reaction_game_core_if.slave  bus
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam int unsigned LK_W  = $clog2(LOCKOUT + 1);
  localparam int unsigned DLY_W = 10;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_READY  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              db_q, db_d;
  logic              db_prev_q, db_prev_d;
  logic [DB_W-1:0]   dbc_q, dbc_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic [LK_W-1:0]   lock_q, lock_d;
  state_e            state_q, state_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic              go_q, go_d;
  logic              fs_q, fs_d;
  logic              to_q, to_d;

  logic              press_c;
  logic              tick_c;

  assign press_c = db_q & ~db_prev_q;
  assign tick_c  = (pre_q == PRE_W'(TICK_DIV - 1));

  // Button synchronizer, debouncer and free-running LFSR.
  always_comb begin
    s1_d      = bus.btn;
    s2_d      = s1_q;
    db_d      = db_q;
    dbc_d     = '0;
    db_prev_d = db_q;
    if (s2_q != db_q) begin
      if (dbc_q == DB_W'(DEBOUNCE - 1)) begin
        db_d  = s2_q;
        dbc_d = '0;
      end else begin
        dbc_d = dbc_q + DB_W'(1);
      end
    end
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Game FSM next state, digit/flag updates, prescaler and lockout counter.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    fs_d    = fs_q;
    to_d    = to_q;
    delay_d = delay_q;
    lock_d  = lock_q;

    case (state_q)
      ST_START: begin
        if (press_c) begin
          state_d = ST_READY;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          fs_d    = 1'b0;
          to_d    = 1'b0;
          delay_d = DLY_W'(MIN_DELAY) + {2'b00, lfsr_q};
        end
      end
      ST_READY: begin
        // A press beats an expiry tick landing in the same cycle.
        if (press_c) begin
          state_d = ST_FINISH;
          tens_d  = 4'd9;
          ones_d  = 4'd9;
          fs_d    = 1'b1;
        end else if (tick_c) begin
          delay_d = delay_q - DLY_W'(1);
          if (delay_q == DLY_W'(1)) begin
            state_d = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        // A press freezes the digits; a coincident tick is not counted.
        if (press_c) begin
          state_d = ST_FINISH;
        end else if (tick_c) begin
          if (tens_q == 4'd9 && ones_q == 4'd9) begin
            state_d = ST_FINISH;
            to_d    = 1'b1;
          end else if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end
      end
      ST_FINISH: begin
        if (press_c && lock_q >= LK_W'(LOCKOUT)) begin
          state_d = ST_START;
        end else if (tick_c && lock_q < LK_W'(LOCKOUT)) begin
          lock_d = lock_q + LK_W'(1);
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase

    // Every state starts with a fresh tick phase and lockout count.
    if (state_d != state_q) begin
      lock_d = '0;
    end
    if (state_d != state_q || tick_c) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    go_d = (state_d == ST_PLAY);
  end

  // All state and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dbc_q     <= '0;
      pre_q     <= '0;
      lfsr_q    <= SEED;
      delay_q   <= '0;
      lock_q    <= '0;
      state_q   <= ST_START;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      go_q      <= 1'b0;
      fs_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      dbc_q     <= dbc_d;
      pre_q     <= pre_d;
      lfsr_q    <= lfsr_d;
      delay_q   <= delay_d;
      lock_q    <= lock_d;
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      go_q      <= go_d;
      fs_q      <= fs_d;
      to_q      <= to_d;
    end
  end

  assign bus.tens        = tens_q;
  assign bus.ones        = ones_q;
  assign bus.state       = state_q;
  assign bus.go          = go_q;
  assign bus.false_start = fs_q;
  assign bus.timeout     = to_q;

endmodule

// File: tb/tb_reaction_game_core.sv
// Directed bench for reaction_game_core with small tick/debounce parameters.
module tb_reaction_game_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] m_lfsr;

  always #5 clk = ~clk;

  reaction_game_core_if bus ();

  reaction_game_core #(
    .TICK_DIV (4),
    .DEBOUNCE (3),
    .MIN_DELAY(2),
    .LOCKOUT  (2),
    .SEED     (8'h01)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR, advanced every clock like the game's random source.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'h01;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  // Button held 4 cycles; returns at the negedge after the state update.
  // lf is the LFSR value during the press cycle.
  task automatic do_press(output logic [7:0] lf);
    bus.btn = 1'b0;
    repeat (3) @(negedge clk);
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.btn = 1'b0;
    @(negedge clk);
    lf = m_lfsr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.btn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", bus.state); end
    checks++; if ({bus.tens, bus.ones} !== 8'h00) begin errors++; $display("FAIL rst_digits got %h want 00", {bus.tens, bus.ones}); end
    checks++; if ({bus.go, bus.false_start, bus.timeout} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {bus.go, bus.false_start, bus.timeout}); end
    checks++; if (dut.lfsr_q !== 8'h01) begin errors++; $display("FAIL rst_lfsr got %h want 01", dut.lfsr_q); end
    reset = 1'b0;
  endtask

  task automatic test_debounce();
    logic [7:0] t;
    bit found;
    // A 2-cycle glitch must not become a press.
    bus.btn = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL bounce_state got %0d want 0", bus.state); end
    checks++; if ({bus.tens, bus.ones} !== 8'h00) begin errors++; $display("FAIL bounce_digits got %h want 00", {bus.tens, bus.ones}); end
    // Raise btn so the press cycle (5 edges on) sees lfsr == 03.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      t = m_lfsr;
      for (int s = 0; s < 5; s++) t = lfsr_step(t);
      if (t == 8'h03) found = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL lfsr_search got none want 03 within 400 cycles"); end
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.btn = 1'b0;
    @(negedge clk);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL press_early got %0d want 0", bus.state); end
    @(negedge clk);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL press_latency got %0d want 1", bus.state); end
    checks++; if ({bus.tens, bus.ones, bus.go, bus.false_start, bus.timeout} !== 11'h000) begin errors++; $display("FAIL ready_entry got %h want 000", {bus.tens, bus.ones, bus.go, bus.false_start, bus.timeout}); end
  endtask

  task automatic test_ready_delay();
    // Delay = 2 + 3 = 5 ticks = 20 cycles from the READY entry edge.
    repeat (19) @(negedge clk);
    checks++; if (bus.state !== 2'd1 || bus.go !== 1'b0) begin errors++; $display("FAIL ready_hold got state %0d go %b want 1 0", bus.state, bus.go); end
    @(negedge clk);
    checks++; if (bus.state !== 2'd2 || bus.go !== 1'b1) begin errors++; $display("FAIL play_entry got state %0d go %b want 2 1", bus.state, bus.go); end
    checks++; if ({bus.tens, bus.ones} !== 8'h00) begin errors++; $display("FAIL play_digits got %h want 00", {bus.tens, bus.ones}); end
  endtask

  task automatic test_reaction();
    // Press cycle 49 cycles into PLAY: 12 ticks counted, 13th not yet due.
    repeat (44) @(negedge clk);
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.btn = 1'b0;
    checks++; if ({bus.tens, bus.ones} !== 8'h12) begin errors++; $display("FAIL count12 got %h want 12", {bus.tens, bus.ones}); end
    @(negedge clk);
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL play_hold got %0d want 2", bus.state); end
    @(negedge clk);
    checks++; if (bus.state !== 2'd3 || {bus.tens, bus.ones} !== 8'h12) begin errors++; $display("FAIL finish got state %0d digits %h want 3 12", bus.state, {bus.tens, bus.ones}); end
    checks++; if ({bus.go, bus.false_start, bus.timeout} !== 3'b000) begin errors++; $display("FAIL finish_flags got %b want 000", {bus.go, bus.false_start, bus.timeout}); end
    // Press accepted at cycle 6 of FINISH, only one tick elapsed: ignored.
    @(negedge clk);
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.btn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL lockout got %0d want 3", bus.state); end
    repeat (3) @(negedge clk);
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.btn = 1'b0;
    @(negedge clk);
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL restart_early got %0d want 3", bus.state); end
    @(negedge clk);
    checks++; if (bus.state !== 2'd0 || {bus.tens, bus.ones} !== 8'h12) begin errors++; $display("FAIL restart got state %0d digits %h want 0 12", bus.state, {bus.tens, bus.ones}); end
  endtask

  task automatic test_false_start();
    logic [7:0] lf;
    int d;
    do_press(lf);
    d = 2 + int'(lf);
    checks++; if (bus.state !== 2'd1 || {bus.tens, bus.ones} !== 8'h00) begin errors++; $display("FAIL fs_ready got state %0d digits %h want 1 00", bus.state, {bus.tens, bus.ones}); end
    // Press cycle coincides with the expiry tick 4*d-1 cycles after entry.
    repeat (4 * d - 6) @(negedge clk);
    bus.btn = 1'b1;
    repeat (4) @(negedge clk);
    bus.btn = 1'b0;
    @(negedge clk);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL fs_collide_pre got %0d want 1", bus.state); end
    @(negedge clk);
    checks++; if (bus.state !== 2'd3 || {bus.tens, bus.ones} !== 8'h99) begin errors++; $display("FAIL fs_finish got state %0d digits %h want 3 99", bus.state, {bus.tens, bus.ones}); end
    checks++; if ({bus.go, bus.false_start, bus.timeout} !== 3'b010) begin errors++; $display("FAIL fs_flags got %b want 010", {bus.go, bus.false_start, bus.timeout}); end
  endtask

  task automatic test_timeout();
    logic [7:0] lf;
    int d;
    repeat (10) @(negedge clk);
    do_press(lf);
    checks++; if (bus.state !== 2'd0 || {bus.tens, bus.ones} !== 8'h99 || bus.false_start !== 1'b1) begin errors++; $display("FAIL start_hold got state %0d digits %h fs %b want 0 99 1", bus.state, {bus.tens, bus.ones}, bus.false_start); end
    do_press(lf);
    d = 2 + int'(lf);
    checks++; if (bus.state !== 2'd1 || bus.false_start !== 1'b0) begin errors++; $display("FAIL flag_clear got state %0d fs %b want 1 0", bus.state, bus.false_start); end
    repeat (4 * d - 1) @(negedge clk);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL to_ready got %0d want 1", bus.state); end
    @(negedge clk);
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL to_play got %0d want 2", bus.state); end
    repeat (36) @(negedge clk);
    checks++; if ({bus.tens, bus.ones} !== 8'h09) begin errors++; $display("FAIL count09 got %h want 09", {bus.tens, bus.ones}); end
    repeat (4) @(negedge clk);
    checks++; if ({bus.tens, bus.ones} !== 8'h10) begin errors++; $display("FAIL carry10 got %h want 10", {bus.tens, bus.ones}); end
    repeat (356) @(negedge clk);
    checks++; if ({bus.tens, bus.ones} !== 8'h99 || bus.state !== 2'd2) begin errors++; $display("FAIL count99 got state %0d digits %h want 2 99", bus.state, {bus.tens, bus.ones}); end
    repeat (3) @(negedge clk);
    checks++; if (bus.state !== 2'd2 || bus.timeout !== 1'b0) begin errors++; $display("FAIL pre_timeout got state %0d to %b want 2 0", bus.state, bus.timeout); end
    @(negedge clk);
    checks++; if (bus.state !== 2'd3 || bus.timeout !== 1'b1 || {bus.tens, bus.ones} !== 8'h99) begin errors++; $display("FAIL timeout got state %0d to %b digits %h want 3 1 99", bus.state, bus.timeout, {bus.tens, bus.ones}); end
    checks++; if (bus.go !== 1'b0 || bus.false_start !== 1'b0) begin errors++; $display("FAIL timeout_flags got go %b fs %b want 0 0", bus.go, bus.false_start); end
  endtask

  task automatic test_reset_mid_play();
    logic [7:0] lf;
    int d;
    repeat (10) @(negedge clk);
    do_press(lf);
    do_press(lf);
    d = 2 + int'(lf);
    repeat (4 * d) @(negedge clk);
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL rmp_play got %0d want 2", bus.state); end
    repeat (148) @(negedge clk);
    checks++; if ({bus.tens, bus.ones} !== 8'h37) begin errors++; $display("FAIL count37 got %h want 37", {bus.tens, bus.ones}); end
    reset   = 1'b1;
    bus.btn = 1'b1;
    @(negedge clk);
    checks++; if (bus.state !== 2'd0 || {bus.tens, bus.ones} !== 8'h00 || bus.go !== 1'b0) begin errors++; $display("FAIL rmp_reset got state %0d digits %h go %b want 0 00 0", bus.state, {bus.tens, bus.ones}, bus.go); end
    checks++; if (dut.lfsr_q !== 8'h01) begin errors++; $display("FAIL rmp_lfsr got %h want 01", dut.lfsr_q); end
    reset   = 1'b0;
    bus.btn = 1'b0;
  endtask

  initial begin
    bus.btn = 1'b0;
    test_reset();
    test_debounce();
    test_ready_delay();
    test_reaction();
    test_false_start();
    test_timeout();
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
